multiplier_datapath: RTL and testbench
======================================

MULTIPLIER_DATAPATH -- requirements
Module: multiplier_datapath

Interface
REQ-001 Parameter: n, default 4, operand width in bits (n >= 2).
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 n_reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 load  input  1  from sequencer reset output; clears accumulator and loads operands.
REQ-005 add_shift  input  1  from sequencer; add multiplicand to accumulator, then shift right.
REQ-006 shift  input  1  from sequencer; shift right without add.
REQ-007 done  input  1  from sequencer ready output; a new product is complete.
REQ-008 multiplicand  input  n  operand M, sampled while load=1.
REQ-009 multiplier  input  n  operand Q, sampled while load=1.
REQ-010 Q0  output  1  LSB of working Q register, fed back to sequencer.
REQ-011 result  output  2n  held product for the downstream consumer.
REQ-012 result_valid  output  1  result holds an unconsumed product.
REQ-013 result_ready  input  1  consumer accepts result this cycle.
REQ-014 overflow  output  1  sticky; a product was dropped because the buffer was full.

Function
REQ-015 Working registers: C (1 bit), A (n bits), Q (n bits), M (n bits); Q0 SHALL equal Q[0] combinationally.
REQ-016 load=1: A<=0, C<=0, Q<=multiplier, M<=multiplicand on the next edge.
REQ-017 add_shift=1 (load=0): {C,A}=A+M at n+1 bits, then {C,A,Q}<={1'b0,C,A,Q[n-1:1]} in the same edge.
REQ-018 shift=1 (load=0, add_shift=0): {C,A,Q}<={1'b0,C,A,Q[n-1:1]} with C=0.
REQ-019 Priority: load > add_shift > shift; none asserted -> all working registers hold.
REQ-020 Product: after n add_shift/shift cycles, {A,Q} SHALL equal multiplicand*multiplier, exact in 2n bits.
REQ-021 Capture event: done=1 and done was 0 in the previous cycle (rising edge detected via a registered copy of done).
REQ-022 On capture, the value {A,Q} present in that cycle (before any concurrent load) SHALL be the one stored.
REQ-023 Capture with result_valid=0: result<={A,Q}, result_valid<=1 on the next edge.
REQ-024 result_valid=1 and result_ready=1 with no capture: result_valid<=0; result holds its value.
REQ-025 Capture, result_valid=1, result_ready=1 same cycle: old result consumed, new stored, result_valid stays 1, overflow unchanged.
REQ-026 Capture, result_valid=1, result_ready=0: new product dropped, result unchanged, overflow<=1.
REQ-027 overflow SHALL stay 1 until n_reset; result_ready has no effect on it.
REQ-028 result and result_valid SHALL be register outputs; result SHALL stay stable while result_valid=1 and result_ready=0.
REQ-029 done held high for many cycles SHALL produce exactly one capture.

Reset
REQ-030 n_reset=0 at an edge: C, A, Q, M, result <= 0; result_valid, overflow, done-delay register <= 0.
REQ-031 Reset mid-multiplication SHALL abandon the operation; Q0 reads 0 the cycle after reset.
REQ-032 Reset SHALL override load, add_shift, shift, capture and result_ready in the same cycle.

Structure
REQ-033 Shared package mult_pkg SHALL hold the default width constant N_DEFAULT=4, also used by the sequencer.
REQ-034 The one-entry output handshake (REQ-023..REQ-028) SHALL be a sub-module result_buffer, parameterised on width 2n.
REQ-035 Working registers and adder SHALL stay in multiplier_datapath; no further sub-modules.

Verification (n=4; pair the DUT with the sequencer)
REQ-036 M=13, Q=11, start pulse, result_ready=1 -> one capture, result=8'h8F, result_valid high 1 cycle, overflow=0.
REQ-037 M=15, Q=15 -> result=8'hE1; M=0, Q=9 -> result=8'h00; Q0 sequence for Q=11 reads 1,1,0,1.
REQ-038 result_ready=0, two products (3*5, 7*7) -> result stays 8'h0F, overflow=1 after second capture; result_ready=1 then clears result_valid.
REQ-039 Capture coincident with result_ready=1 while result_valid=1 -> new value stored, result_valid stays 1, overflow=0.
REQ-040 n_reset=0 two cycles into a multiply -> all outputs 0 next cycle; a following 6*7 yields 8'h2A.
REQ-041 Direct drive: load, add_shift and shift together -> load wins; done held 10 cycles -> exactly one capture.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: default operand width and
// the datapath operation decode used by the datapath (and its sequencer).
package mult_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_ADD_SHIFT,
        OP_SHIFT
    } dp_op_e;

    // load beats add_shift beats shift; nothing asserted means hold.
    function automatic dp_op_e decode_op(input logic load,
                                         input logic add_shift,
                                         input logic shift);
        if (load)
            return OP_LOAD;
        else if (add_shift)
            return OP_ADD_SHIFT;
        else if (shift)
            return OP_SHIFT;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/result_buffer.sv
// One-entry output buffer with valid/ready handshake; drops a new product and
// raises a sticky overflow flag when the held product has not been consumed.
module result_buffer #(
    parameter int width = 8
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             capture,
    input  logic [width-1:0] data,
    input  logic             result_ready,
    output logic [width-1:0] result,
    output logic             result_valid,
    output logic             overflow
);

    logic can_accept;

    // A slot frees up either when empty or when the consumer takes it this cycle.
    assign can_accept = !result_valid || result_ready;

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else if (capture) begin
            if (can_accept) begin
                result       <= data;
                result_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/multiplier_datapath.sv
// Shift-add multiplier datapath: C/A/Q/M working registers driven by an external
// sequencer, with a one-entry result buffer fed on each rising edge of done.
module multiplier_datapath
    import mult_pkg::*;
#(
    parameter int n = N_DEFAULT
) (
    input  logic           clock,
    input  logic           n_reset,
    input  logic           load,
    input  logic           add_shift,
    input  logic           shift,
    input  logic           done,
    input  logic [n-1:0]   multiplicand,
    input  logic [n-1:0]   multiplier,
    output logic           Q0,
    output logic [2*n-1:0] result,
    output logic           result_valid,
    input  logic           result_ready,
    output logic           overflow
);

    dp_op_e       op;
    logic [n:0]   sum;
    logic         c_reg;
    logic [n-1:0] a_reg;
    logic [n-1:0] q_reg;
    logic [n-1:0] m_reg;
    logic         done_d;
    logic         capture;

    always_comb begin
        op  = decode_op(load, add_shift, shift);
        sum = {1'b0, a_reg} + {1'b0, m_reg};
    end

    // C is always 0 outside an add, so the shift path zero-fills through it.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            c_reg  <= 1'b0;
            a_reg  <= '0;
            q_reg  <= '0;
            m_reg  <= '0;
            done_d <= 1'b0;
        end else begin
            done_d <= done;
            case (op)
                OP_LOAD: begin
                    c_reg <= 1'b0;
                    a_reg <= '0;
                    q_reg <= multiplier;
                    m_reg <= multiplicand;
                end
                OP_ADD_SHIFT: {c_reg, a_reg, q_reg} <= {1'b0, sum, q_reg[n-1:1]};
                OP_SHIFT:     {c_reg, a_reg, q_reg} <= {1'b0, c_reg, a_reg, q_reg[n-1:1]};
                default: ;
            endcase
        end
    end

    assign Q0      = q_reg[0];
    assign capture = done && !done_d;

    // The buffer samples {A,Q} as it stands this cycle, ahead of any concurrent load.
    result_buffer #(
        .width(2 * n)
    ) u_result_buffer (
        .clock       (clock),
        .n_reset     (n_reset),
        .capture     (capture),
        .data        ({a_reg, q_reg}),
        .result_ready(result_ready),
        .result      (result),
        .result_valid(result_valid),
        .overflow    (overflow)
    );

endmodule

// File: tb/tb_multiplier_datapath.sv
// Self-checking bench for multiplier_datapath (n=4) with a behavioural sequencer
// and a scoreboard of expected products.
module tb_multiplier_datapath;
    import mult_pkg::*;

    localparam int N = N_DEFAULT;

    logic           clock = 1'b0;
    logic           n_reset;
    logic           load;
    logic           add_shift;
    logic           shift;
    logic           done;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           q0;
    logic [2*N-1:0] result;
    logic           result_valid;
    logic           result_ready;
    logic           overflow;

    int checks   = 0;
    int failures = 0;

    logic [2*N-1:0] exp_q[$];
    logic           q0_log[$];

    always #5 clock = ~clock;

    multiplier_datapath #(.n(N)) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .load        (load),
        .add_shift   (add_shift),
        .shift       (shift),
        .done        (done),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .Q0          (q0),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .overflow    (overflow)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        load      = 1'b0;
        add_shift = 1'b0;
        shift     = 1'b0;
        done      = 1'b0;
    endtask

    // Behavioural sequencer: load, n add/shift steps chosen by Q0, one-cycle done pulse.
    task automatic drive_multiply(input logic [N-1:0] m, input logic [N-1:0] q,
                                  input logic ready_busy, input logic ready_done,
                                  input logic accepted);
        logic [2*N-1:0] mm;
        logic [2*N-1:0] qq;
        mm = {{N{1'b0}}, m};
        qq = {{N{1'b0}}, q};
        result_ready = ready_busy;
        multiplicand = m;
        multiplier   = q;
        load = 1'b1;
        tick();
        load = 1'b0;
        q0_log.delete();
        for (int i = 0; i < N; i++) begin
            q0_log.push_back(q0);
            add_shift = q0;
            shift     = ~q0;
            tick();
        end
        add_shift = 1'b0;
        shift     = 1'b0;
        if (accepted) exp_q.push_back(mm * qq);
        done = 1'b1;
        result_ready = ready_done;
        tick();
        done = 1'b0;
        result_ready = ready_busy;
    endtask

    task automatic test_reset();
        idle_inputs();
        result_ready = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        n_reset = 1'b0;
        tick();
        tick();
        n_reset = 1'b1;
        checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result: got %h want 00", result); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (q0 !== 1'b0) begin failures++; $display("FAIL reset_q0: got %b want 0", q0); end
    endtask

    task automatic test_basic();
        logic [2*N-1:0] exp;
        logic           exp_seq[4];
        exp_seq = '{1'b1, 1'b1, 1'b0, 1'b1};
        drive_multiply(4'd13, 4'd11, 1'b1, 1'b1, 1'b1);
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b want 1", result_valid); end
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL basic_scoreboard: got empty queue want one entry");
        end else begin
            exp = exp_q.pop_front();
            if (result !== exp) begin failures++; $display("FAIL basic_product: got %h want %h", result, exp); end
        end
        checks++; if (result !== 8'h8F) begin failures++; $display("FAIL basic_const: got %h want 8f", result); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q0_log[i] !== exp_seq[i]) begin
                failures++; $display("FAIL basic_q0_seq[%0d]: got %b want %b", i, q0_log[i], exp_seq[i]);
            end
        end
        tick();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_pulse: got %b want 0", result_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow: got %b want 0", overflow); end
        checks++; if (result !== 8'h8F) begin failures++; $display("FAIL basic_hold: got %h want 8f", result); end
    endtask

    task automatic test_corners();
        logic [2*N-1:0] exp;
        drive_multiply(4'd15, 4'd15, 1'b1, 1'b1, 1'b1);
        exp = exp_q.pop_front();
        checks++; if (result !== exp || result !== 8'hE1) begin failures++; $display("FAIL corner_15x15: got %h want %h", result, exp); end
        drive_multiply(4'd0, 4'd9, 1'b1, 1'b1, 1'b1);
        exp = exp_q.pop_front();
        checks++; if (result !== exp || result !== 8'h00) begin failures++; $display("FAIL corner_0x9: got %h want %h", result, exp); end
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL corner_valid: got %b want 1", result_valid); end
        tick();
    endtask

    task automatic test_overflow();
        logic [2*N-1:0] exp;
        drive_multiply(4'd3, 4'd5, 1'b0, 1'b0, 1'b1);
        exp = exp_q.pop_front();
        checks++; if (result !== exp) begin failures++; $display("FAIL ovf_first: got %h want %h", result, exp); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", overflow); end
        drive_multiply(4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
        checks++; if (result !== 8'h0F) begin failures++; $display("FAIL ovf_hold: got %h want 0f", result); end
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid: got %b want 1", result_valid); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", overflow); end
        result_ready = 1'b1;
        tick();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL ovf_consume: got %b want 0", result_valid); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_reset: got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] exp;
        drive_multiply(4'd2, 4'd3, 1'b0, 1'b0, 1'b1);
        exp = exp_q.pop_front();
        checks++; if (result !== exp) begin failures++; $display("FAIL b2b_first: got %h want %h", result, exp); end
        drive_multiply(4'd5, 4'd9, 1'b0, 1'b1, 1'b1);
        exp = exp_q.pop_front();
        checks++; if (result !== exp) begin failures++; $display("FAIL b2b_second: got %h want %h", result, exp); end
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b want 1", result_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
        result_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [2*N-1:0] exp;
        result_ready = 1'b1;
        multiplicand = 4'd9;
        multiplier   = 4'd13;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            add_shift = q0;
            shift     = ~q0;
            tick();
        end
        load = 1'b1; add_shift = 1'b1; shift = 1'b1; done = 1'b1;
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        idle_inputs();
        checks++; if (q0 !== 1'b0) begin failures++; $display("FAIL mid_reset_q0: got %b want 0", q0); end
        checks++; if (result !== 8'h00) begin failures++; $display("FAIL mid_reset_result: got %h want 00", result); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b want 0", result_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mid_reset_overflow: got %b want 0", overflow); end
        drive_multiply(4'd6, 4'd7, 1'b1, 1'b1, 1'b1);
        exp = exp_q.pop_front();
        checks++; if (result !== exp || result !== 8'h2A) begin failures++; $display("FAIL mid_reset_6x7: got %h want %h", result, exp); end
        tick();
    endtask

    task automatic test_direct();
        logic [2*N-1:0] exp;
        int             valid_cycles;
        result_ready = 1'b1;
        multiplicand = 4'd3;
        multiplier   = 4'd5;
        load = 1'b1; add_shift = 1'b1; shift = 1'b1;
        tick();
        idle_inputs();
        checks++; if (q0 !== 1'b1) begin failures++; $display("FAIL direct_q0_after_load: got %b want 1", q0); end
        for (int i = 0; i < N; i++) begin
            add_shift = q0;
            shift     = ~q0;
            tick();
        end
        idle_inputs();
        exp_q.push_back(8'd15);
        valid_cycles = 0;
        done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (result_valid) valid_cycles++;
            if (i == 0) begin
                exp = exp_q.pop_front();
                checks++; if (result !== exp) begin failures++; $display("FAIL direct_product: got %h want %h", result, exp); end
            end
        end
        done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (result_valid) valid_cycles++;
        end
        checks++; if (valid_cycles !== 1) begin failures++; $display("FAIL direct_single_capture: got %0d want 1", valid_cycles); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL direct_overflow: got %b want 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_direct();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
